seq_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider: the inverse of combi_logic's multiplier.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_div_step.sv | 26 ++
 rtl/seq_divider.sv | 107 ++++++++++
 tb/tb_seq_divider.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default widths and FSM encoding.
package seq_divider_pkg;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract the divisor, set the new quotient bit.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0]  r,
  input  logic [DIVIDEND_W-1:0] q,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVISOR_W-1:0]  r_next,
  output logic [DIVIDEND_W-1:0] q_next
);

  logic [DIVISOR_W:0] shifted;
  logic               ge;

  // The shifted remainder needs one extra bit; after restoring it always fits back in DIVISOR_W.
  always_comb begin
    shifted = {r, q[DIVIDEND_W-1]};
    ge      = (shifted >= {1'b0, divisor});
    r_next  = ge ? DIVISOR_W'(shifted - {1'b0, divisor}) : shifted[DIVISOR_W-1:0];
    q_next  = {q[DIVIDEND_W-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
//
// state  | meaning
// IDLE   | waiting for i_start; operands captured on the accepted edge
// CALC   | one iteration per cycle while cnt != 0; cnt == 0 loads the results
//        | (a zero divisor enters with cnt = 0, so it spends a single cycle here)
// DONE   | o_done pulse, results valid; i_start ignored
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVISOR_W-1:0]  i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DIVIDEND_W-1:0] o_quotient,
  output logic [DIVISOR_W-1:0]  o_remainder,
  output logic                  o_div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic                  zero_q;
  logic [DIVISOR_W-1:0]  rem_next;
  logic [DIVIDEND_W-1:0] quo_next;

  div_step #(
    .DIVIDEND_W(DIVIDEND_W),
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r      (rem_q),
    .q      (quo_q),
    .divisor(dsr_q),
    .r_next (rem_next),
    .q_next (quo_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dsr_q         <= '0;
      zero_q        <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            quo_q  <= i_dividend;
            dsr_q  <= i_divisor;
            rem_q  <= '0;
            zero_q <= (i_divisor == '0);
            cnt    <= (i_divisor == '0) ? '0 : CNT_W'(DIVIDEND_W);
            o_busy <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (cnt == '0) begin
            state         <= S_DONE;
            o_done        <= 1'b1;
            o_div_by_zero <= zero_q;
            if (zero_q) begin
              o_quotient  <= '1;
              o_remainder <= quo_q[DIVISOR_W-1:0];
            end else begin
              o_quotient  <= quo_q;
              o_remainder <= rem_q;
            end
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider results, latency, handshake and reset.
module tb_seq_divider;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_dividend;
  logic [7:0]  i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_quotient;
  logic [7:0]  o_remainder;
  logic        o_div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called #1 after a rising edge with the divider idle; returns lat = -1 on timeout.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] q, output logic [7:0] r,
                        output logic z, output int lat);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = -1; q = '0; r = '0; z = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge i_clk); #1;
      if (o_done) begin
        lat = k; q = o_quotient; r = o_remainder; z = o_div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
    repeat (2) @(posedge i_clk);
    #1;
    n_tests++;
    if ({o_busy, o_done, o_quotient, o_remainder, o_div_by_zero} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
               o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
    end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] q; logic [7:0] r; logic z; int lat;
    run_op(16'd2048, 8'd64, q, r, z, lat);
    n_tests++;
    if (q !== 16'd32 || r !== 8'd0 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_2048_64: q=%0d r=%0d dbz=%b, want q=32 r=0 dbz=0", q, r, z);
    end
    n_tests++;
    if (lat !== 17) begin
      n_fail++;
      $display("FAIL basic_latency: %0d edges, want 17", lat);
    end
    @(posedge i_clk); #1;
    n_tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b busy=%b one cycle later, want 0 0", o_done, o_busy);
    end
    n_tests++;
    if (o_quotient !== 16'd32 || o_remainder !== 8'd0) begin
      n_fail++;
      $display("FAIL result_hold: q=%0d r=%0d, want 32 0", o_quotient, o_remainder);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] a_t [3] = '{16'd65025, 16'd1000, 16'd5};
    logic [7:0]  b_t [3] = '{8'd255, 8'd7, 8'd200};
    logic [15:0] q_t [3] = '{16'd255, 16'd142, 16'd0};
    logic [7:0]  r_t [3] = '{8'd0, 8'd6, 8'd5};
    logic [15:0] q; logic [7:0] r; logic z; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(a_t[i], b_t[i], q, r, z, lat);
      n_tests++;
      if (q !== q_t[i] || r !== r_t[i] || z !== 1'b0 || lat !== 17) begin
        n_fail++;
        $display("FAIL vector_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=0 lat=17",
                 a_t[i], b_t[i], q, r, z, lat, q_t[i], r_t[i]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q; logic [7:0] r; logic z; int lat;
    run_op(16'h1234, 8'd0, q, r, z, lat);
    n_tests++;
    if (q !== 16'hFFFF || r !== 8'h34 || z !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero_result: q=%h r=%h dbz=%b, want q=ffff r=34 dbz=1", q, r, z);
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL div_zero_latency: %0d edges, want 1", lat);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_back_to_back();
    int dones = 0, done_k = 100, busy_drop = 0, busy_late = 0;
    logic [15:0] q = '0; logic [7:0] r = '0;
    i_dividend = 16'd2400; i_divisor = 8'd12; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      i_start = (k == 5) || (k == done_k + 1);
      if (k == 5) begin i_dividend = 16'd9; i_divisor = 8'd3; end
      @(posedge i_clk); #1;
      if (o_done) begin
        dones++;
        if (done_k == 100) begin done_k = k; q = o_quotient; r = o_remainder; end
      end
      if (done_k == 100 && !o_busy) busy_drop++;
      if (k > done_k && o_busy) busy_late++;
    end
    i_start = 1'b0;
    n_tests++;
    if (dones !== 1 || done_k !== 17) begin
      n_fail++;
      $display("FAIL b2b_single_done: %0d dones, first at %0d, want 1 at 17", dones, done_k);
    end
    n_tests++;
    if (q !== 16'd200 || r !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_result: q=%0d r=%0d, want 200 0", q, r);
    end
    n_tests++;
    if (busy_drop !== 0 || busy_late !== 0) begin
      n_fail++;
      $display("FAIL b2b_busy: %0d low cycles in op, %0d high cycles after, want 0 0",
               busy_drop, busy_late);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    logic [15:0] q; logic [7:0] r; logic z; int lat;
    i_dividend = 16'd1540; i_divisor = 8'd28; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (7) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    n_tests++;
    if ({o_busy, o_done, o_quotient, o_remainder, o_div_by_zero} !== 26'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
               o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
    end
    i_rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) stray++;
    end
    n_tests++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: %0d cycles with done/busy after reset, want 0", stray);
    end
    run_op(16'd1540, 8'd28, q, r, z, lat);
    n_tests++;
    if (q !== 16'd55 || r !== 8'd0 || z !== 1'b0 || lat !== 17) begin
      n_fail++;
      $display("FAIL after_reset_1540_28: q=%0d r=%0d dbz=%b lat=%0d, want 55 0 0 17", q, r, z, lat);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] a, q; logic [7:0] b, r; logic z; int lat;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, q, r, z, lat);
      n_tests++;
      if (q !== a / 16'(b) || r !== 8'(a % 16'(b)) || z !== 1'b0 ||
          (32'(q) * 32'(b) + 32'(r)) !== 32'(a) || r >= b) begin
        n_fail++;
        $display("FAIL random_%0d_%0d: q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                 a, b, q, r, z, a / 16'(b), a % 16'(b));
      end
      n_tests++;
      if (lat !== 17) begin
        n_fail++;
        $display("FAIL random_latency_%0d_%0d: %0d edges, want 17", a, b, lat);
      end
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
